// File: rtl/button_event_scheduler.sv
// Debounces NUM_BTN raw buttons on a shared sample tick, turns level changes into
// press/release/long-press events and queues them in a first-word-fall-through FIFO.
module button_event_scheduler #(
  parameter int NUM_BTN    = 4,
  parameter int TICK_DIV   = 250000,
  parameter int HOLD_TICKS = 100,
  parameter int FIFO_DEPTH = 8,
  localparam int BTN_W     = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_state,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [BTN_W-1:0]   evt_btn,
  output logic [1:0]         evt_type,
  output logic               overflow,
  input  logic               ovf_clr
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HC_W  = $clog2(HOLD_TICKS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = BTN_W + 2;

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  logic [NUM_BTN-1:0] sync1_r;
  logic [NUM_BTN-1:0] sync2_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               tick_s;

  logic [1:0]         hist_r     [NUM_BTN];
  logic [HC_W-1:0]    hold_cnt_r [NUM_BTN];
  logic [1:0]         pend_t_r   [NUM_BTN];
  logic [NUM_BTN-1:0] pend_v_r;
  logic [NUM_BTN-1:0] btn_state_r;
  logic [NUM_BTN-1:0] rise_s;
  logic [NUM_BTN-1:0] fall_s;
  logic [NUM_BTN-1:0] long_s;
  logic               set_any_s;

  state_t             state_r;
  state_t             state_nx_s;
  logic [BTN_W-1:0]   idx_r;
  logic [BTN_W-1:0]   idx_nx_s;
  logic [NUM_BTN-1:0] clr_s;
  logic               push_s;
  logic [EW-1:0]      push_data_s;

  logic [EW-1:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW:0]        count_r;
  logic               overflow_r;
  logic               empty_s;
  logic               full_s;
  logic               pop_s;
  logic               push_ok_s;
  logic               drop_s;
  logic [EW-1:0]      head_s;

  assign tick_s = (cnt_r == CNT_W'(TICK_DIV - 1));

  // Two-flop input synchroniser and free-running sample-tick divider
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
      cnt_r   <= tick_s ? '0 : cnt_r + CNT_W'(1);
    end
  end

  // Per-button transition detection; a level change needs three agreeing samples
  always_comb begin
    rise_s = '0;
    fall_s = '0;
    long_s = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (tick_s && sync2_r[i] && hist_r[i][0] && hist_r[i][1] && !btn_state_r[i]) begin
        rise_s[i] = 1'b1;
      end else if (tick_s && !sync2_r[i] && !hist_r[i][0] && !hist_r[i][1] && btn_state_r[i]) begin
        fall_s[i] = 1'b1;
      end else if (tick_s && btn_state_r[i] && (hold_cnt_r[i] == HC_W'(HOLD_TICKS - 1))) begin
        long_s[i] = 1'b1;
      end else begin
        long_s[i] = 1'b0;
      end
    end
  end

  assign set_any_s = |(rise_s | fall_s | long_s);

  // Debounced level, sample history, hold counters and pending events
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_state_r <= '0;
      pend_v_r    <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        hist_r[i]     <= 2'b00;
        hold_cnt_r[i] <= '0;
        pend_t_r[i]   <= 2'b00;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (tick_s) begin
          hist_r[i] <= {hist_r[i][0], sync2_r[i]};
          if (rise_s[i]) begin
            btn_state_r[i] <= 1'b1;
            hold_cnt_r[i]  <= '0;
            pend_v_r[i]    <= 1'b1;
            pend_t_r[i]    <= EV_PRESS;
          end else if (fall_s[i]) begin
            btn_state_r[i] <= 1'b0;
            pend_v_r[i]    <= 1'b1;
            pend_t_r[i]    <= EV_RELEASE;
          end else if (btn_state_r[i] && (hold_cnt_r[i] != HC_W'(HOLD_TICKS))) begin
            // saturating at HOLD_TICKS makes the long-press fire once per press
            hold_cnt_r[i] <= hold_cnt_r[i] + HC_W'(1);
            if (long_s[i]) begin
              pend_v_r[i] <= 1'b1;
              pend_t_r[i] <= EV_LONG;
            end
          end
        end else if (clr_s[i]) begin
          pend_v_r[i] <= 1'b0;
        end
      end
    end
  end

  // Scan FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
    end
  end

  // Scan FSM next state: one button per cycle, lowest index first
  always_comb begin
    state_nx_s  = state_r;
    idx_nx_s    = idx_r;
    clr_s       = '0;
    push_s      = 1'b0;
    push_data_s = {idx_r, pend_t_r[idx_r]};
    case (state_r)
      IDLE: begin
        if (set_any_s) begin
          state_nx_s = SCAN;
          idx_nx_s   = '0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SCAN: begin
        push_s       = pend_v_r[idx_r];
        clr_s[idx_r] = 1'b1;
        if (idx_r == BTN_W'(NUM_BTN - 1)) begin
          state_nx_s = IDLE;
          idx_nx_s   = '0;
        end else begin
          idx_nx_s = idx_r + BTN_W'(1);
        end
      end
      default: begin
        state_nx_s = IDLE;
        idx_nx_s   = '0;
      end
    endcase
  end

  assign empty_s   = (count_r == '0);
  assign full_s    = (count_r == (AW + 1)'(FIFO_DEPTH));
  assign pop_s     = !empty_s && evt_ready;
  assign push_ok_s = push_s && (!full_s || pop_s);
  assign drop_s    = push_s && !push_ok_s;
  assign head_s    = mem_r[rd_ptr_r];

  // Event FIFO storage, pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        mem_r[j] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign btn_state = btn_state_r;
  assign evt_valid = !empty_s;
  assign evt_btn   = empty_s ? '0 : head_s[EW-1:2];
  assign evt_type  = empty_s ? 2'b00 : head_s[1:0];
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: event-level reference model checked every cycle,
// a table of button scenarios and hand-written overflow, latency and reset sequences.
module tb_button_event_scheduler;

  localparam int NB   = 4;
  localparam int TDIV = 8;
  localparam int HOLD = 5;
  localparam int DEP  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] btn_state;
  logic          evt_valid;
  logic          evt_ready = 1'b1;
  logic [1:0]    evt_btn;
  logic [1:0]    evt_type;
  logic          overflow;
  logic          ovf_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  button_event_scheduler #(
    .NUM_BTN(NB), .TICK_DIV(TDIV), .HOLD_TICKS(HOLD), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_state(btn_state),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_btn(evt_btn),
    .evt_type(evt_type), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // reference model: events scheduled for the cycle the spec says they are pushed
  typedef struct {int at; logic [3:0] code;} sched_t;
  sched_t     sched_q[$];
  logic [3:0] fifo_q[$];
  logic [3:0] got_q[$];
  int         k;
  logic [NB-1:0] d1, d2, lvl;
  logic [2:0] smp [NB];
  int         hold_t [NB];
  logic       m_ovf;
  logic       collect = 1'b0;
  logic [NB-1:0] seen_state;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; d1 = '0; d2 = '0; lvl = '0; m_ovf = 1'b0;
    for (int i = 0; i < NB; i++) begin smp[i] = 3'b000; hold_t[i] = 0; end
    sched_q.delete();
    fifo_q.delete();
  endtask

  task automatic add_evt(input int i, input logic [1:0] t);
    sched_t s;
    logic [1:0] b;
    b = i[1:0];
    s.at = k + i + 1;
    s.code = {b, t};
    sched_q.push_back(s);
  endtask

  // advance the model across one rising edge using the inputs currently driven
  task automatic model_edge();
    logic dropped;
    if (reset) begin
      model_reset();
      return;
    end
    k++;
    dropped = 1'b0;
    if (fifo_q.size() > 0 && evt_ready) void'(fifo_q.pop_front());
    for (int j = 0; j < sched_q.size(); j++) begin
      if (sched_q[j].at == k) begin
        if (fifo_q.size() < DEP) fifo_q.push_back(sched_q[j].code);
        else dropped = 1'b1;
      end
    end
    for (int j = sched_q.size() - 1; j >= 0; j--) begin
      if (sched_q[j].at <= k) sched_q.delete(j);
    end
    if (dropped) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (k % TDIV == 0) begin
      for (int i = 0; i < NB; i++) begin
        smp[i] = {smp[i][1:0], d2[i]};
        if (smp[i] == 3'b111 && !lvl[i]) begin
          lvl[i] = 1'b1; hold_t[i] = 0; add_evt(i, 2'b00);
        end else if (smp[i] == 3'b000 && lvl[i]) begin
          lvl[i] = 1'b0; add_evt(i, 2'b01);
        end else if (lvl[i] && hold_t[i] < HOLD) begin
          hold_t[i]++;
          if (hold_t[i] == HOLD) add_evt(i, 2'b10);
        end
      end
    end
    d2 = d1;
    d1 = btn_in;
  endtask

  task automatic compare();
    chk("btn_state", {4'h0, btn_state}, {4'h0, lvl});
    chk("evt_valid", {7'h0, evt_valid}, {7'h0, fifo_q.size() > 0});
    if (fifo_q.size() > 0) chk("evt_head", {4'h0, evt_btn, evt_type}, {4'h0, fifo_q[0]});
    chk("overflow", {7'h0, overflow}, {7'h0, m_ovf});
  endtask

  task automatic step();
    if (collect && evt_valid && evt_ready) got_q.push_back({evt_btn, evt_type});
    model_edge();
    @(posedge clk);
    #1;
    seen_state |= btn_state;
    compare();
  endtask

  typedef struct {
    logic [3:0]  btn;
    int          hold;
    logic [3:0]  exp_seen;
    int          n_exp;
    logic [15:0] exp_ev;
  } vec_t;
  vec_t vecs [5];

  logic [3:0] ovf_exp [4];
  int         stale;

  initial begin
    // {buttons, clocks held, btn_state ever seen, event count, events oldest in low nibble}
    vecs[0] = '{4'b0100, 80, 4'b0100, 3, {4'h0, 4'b1001, 4'b1010, 4'b1000}};
    vecs[1] = '{4'b0001, 10, 4'b0000, 0, 16'h0000};
    vecs[2] = '{4'b0001, 1,  4'b0000, 0, 16'h0000};
    vecs[3] = '{4'b0010, 24, 4'b0010, 2, {8'h00, 4'b0101, 4'b0100}};
    vecs[4] = '{4'b1001, 40, 4'b1001, 4, {4'b1101, 4'b0001, 4'b1100, 4'b0000}};
    ovf_exp[0] = 4'b0000; ovf_exp[1] = 4'b0100; ovf_exp[2] = 4'b1000; ovf_exp[3] = 4'b0001;
    model_reset();
    seen_state = '0;

    for (int n = 0; n < 3; n++) step();
    reset = 1'b0;
    chk("rst_valid", {7'h0, evt_valid}, 8'h00);
    chk("rst_state", {4'h0, btn_state}, 8'h00);
    chk("rst_head", {4'h0, evt_btn, evt_type}, 8'h00);
    chk("rst_ovf", {7'h0, overflow}, 8'h00);

    for (int v = 0; v < 5; v++) begin
      got_q.delete();
      seen_state = '0;
      collect = 1'b1;
      btn_in = vecs[v].btn;
      for (int n = 0; n < vecs[v].hold; n++) step();
      btn_in = '0;
      for (int n = 0; n < 56; n++) step();
      collect = 1'b0;
      chk($sformatf("vec%0d_seen", v), {4'h0, seen_state}, {4'h0, vecs[v].exp_seen});
      chk($sformatf("vec%0d_nevt", v), 8'(got_q.size()), 8'(vecs[v].n_exp));
      for (int j = 0; j < vecs[v].n_exp && j < got_q.size(); j++)
        chk($sformatf("vec%0d_evt%0d", v, j), {4'h0, got_q[j]}, {4'h0, vecs[v].exp_ev[j*4 +: 4]});
    end

    // overflow: six events into a four-entry FIFO with the consumer stalled
    evt_ready = 1'b0;
    btn_in = 4'b0111;
    for (int n = 0; n < 24; n++) step();
    btn_in = '0;
    for (int n = 0; n < 56; n++) step();
    chk("ovf_set", {7'h0, overflow}, 8'h01);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", {7'h0, overflow}, 8'h00);
    evt_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("ovf_drain%0d", j), {4'h0, evt_btn, evt_type}, {4'h0, ovf_exp[j]});
      step();
    end
    chk("ovf_empty", {7'h0, evt_valid}, 8'h00);

    // push latency: button 0 visible 1 clk after the debounce edge, button 3 at 4 clk
    btn_in = 4'b1001;
    for (int n = 0; n < 100 && !btn_state[0]; n++) step();
    chk("lat_rise", {7'h0, btn_state[0]}, 8'h01);
    step();
    chk("lat_b0_valid", {7'h0, evt_valid}, 8'h01);
    chk("lat_b0_head", {4'h0, evt_btn, evt_type}, 8'h00);
    step();
    chk("lat_gap1", {7'h0, evt_valid}, 8'h00);
    step();
    chk("lat_gap2", {7'h0, evt_valid}, 8'h00);
    step();
    chk("lat_b3_valid", {7'h0, evt_valid}, 8'h01);
    chk("lat_b3_head", {4'h0, evt_btn, evt_type}, 8'h0C);
    btn_in = '0;
    for (int n = 0; n < 64; n++) step();

    // reset during a scan with two pending presses
    btn_in = 4'b0011;
    for (int n = 0; n < 100 && sched_q.size() == 0; n++) step();
    chk("scan_armed", {4'h0, btn_state}, 8'h03);
    reset = 1'b1;
    btn_in = '0;
    step();
    reset = 1'b0;
    chk("scan_rst_valid", {7'h0, evt_valid}, 8'h00);
    chk("scan_rst_state", {4'h0, btn_state}, 8'h00);
    stale = 0;
    for (int n = 0; n < 64; n++) begin
      step();
      if (evt_valid) stale++;
    end
    chk("scan_rst_stale", 8'(stale), 8'h00);

    // randomized buttons, consumer stalls and overflow clears against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) btn_in[$urandom_range(0, NB - 1)] ^= 1'b1;
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 63) == 0);
      reset = (n == 2000);
      step();
    end
    reset = 1'b0;
    ovf_clr = 1'b0;
    evt_ready = 1'b1;
    btn_in = '0;
    for (int n = 0; n < 80; n++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
